regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: port 0 (ALU) and port 1 (load unit). Uses round-robin arbitration and one registered write stage. It also provides read-side hazard and bypass information, so the decode stage never reads a stale value while a write is in flight. It sits between the execute/memory writeback paths and the 32×32 register file (write port: `we`/`waddr`/`wdata`; register 0 reads as zero).

---
 rtl/rf_pkg.sv | 24 ++
 rtl/regfile_wb_arbiter_if.sv | 42 ++++
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file writeback arbiter.
//   WIDTH      data bits per register
//   DEPTH      number of registers
//   AW         register address width
//   wb_req_t   one writeback request {valid, addr, data}
//   lg_e       round-robin "last granted" encoding (LG0 / LG1)
package rf_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    LG0 = 1'b0,
    LG1 = 1'b1
  } lg_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request handshakes and register-file write port.
//   req0_* / req1_*   writeback requests (valid/addr/data in, ready out of the arbiter)
//   rf_we/waddr/wdata register file write port, driven by the arbiter
// Handshake: a request is accepted in a cycle where valid && ready. While
// valid && !ready the requester keeps addr/data stable. ready is a
// combinational grant and never depends on a downstream stall.
interface regfile_wb_arbiter_if;
  import rf_pkg::*;

  logic             req0_valid;
  logic [AW-1:0]    req0_addr;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;

  logic             req1_valid;
  logic [AW-1:0]    req1_addr;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;

  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  // Requester / register-file side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant.
//   clk, rst      clock, synchronous active-high reset
//   req0, req1    request lines
//   gnt0, gnt1    one-hot (or zero) combinational grant
//   last_grant    current round-robin state, exported for observation
// The last_grant register only moves when a grant is issued, so an idle
// cycle does not disturb fairness. Reset leaves LG1 so port 0 wins the
// first contention. No grant is issued while rst is high.
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output lg_e  last_grant
);

  lg_e last_grant_q;
  lg_e last_grant_d;

  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      if (req0 && req1) begin
        // Contention: the port not served most recently wins.
        gnt0 = (last_grant_q == LG1);
        gnt1 = (last_grant_q == LG0);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
      if (gnt0) begin
        last_grant_d = LG0;
      end else if (gnt1) begin
        last_grant_d = LG1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LG1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// the ALU (port 0) and the load unit (port 1), with one registered write
// stage plus decode-side bypass and hazard information.
//   clk, rst            clock, synchronous active-high reset
//   bus (slave)         writeback requests in, register-file write port out
//   raddr1, raddr2      decode-stage read addresses
//   fwd1_hit/fwd2_hit   staged write targets the read address; use fwd*_data
//   fwd1_data/fwd2_data staged write data
//   busy1, busy2        a pending request (granted or not) targets the read address
//   dbg_last_grant      round-robin arbiter state
module regfile_wb_arbiter
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  regfile_wb_arbiter_if.slave bus,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic [WIDTH-1:0] fwd1_data,
  output logic [WIDTH-1:0] fwd2_data,
  output logic             busy1,
  output logic             busy2,
  output lg_e              dbg_last_grant
);

  wb_req_t req0;
  wb_req_t req1;
  wb_req_t win_req;
  logic    gnt0;
  logic    gnt1;

  logic             stage_v_q,    stage_v_d;
  logic [AW-1:0]    stage_addr_q, stage_addr_d;
  logic [WIDTH-1:0] stage_data_q, stage_data_d;

  always_comb begin
    req0 = '{valid: bus.req0_valid, addr: bus.req0_addr, data: bus.req0_data};
    req1 = '{valid: bus.req1_valid, addr: bus.req1_addr, data: bus.req1_data};
  end

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0.valid),
    .req1       (req1.valid),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .last_grant (dbg_last_grant)
  );

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // The register file accepts a write every cycle, so the stage drains
  // unconditionally; it is refilled only by an accepted request. Writes to
  // register 0 are accepted but never raise the write enable.
  always_comb begin
    win_req      = gnt0 ? req0 : req1;
    stage_v_d    = 1'b0;
    stage_addr_d = stage_addr_q;
    stage_data_d = stage_data_q;
    if (gnt0 || gnt1) begin
      stage_v_d    = (win_req.addr != '0);
      stage_addr_d = win_req.addr;
      stage_data_d = win_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v_q    <= 1'b0;
      stage_addr_q <= '0;
      stage_data_q <= '0;
    end else begin
      stage_v_q    <= stage_v_d;
      stage_addr_q <= stage_addr_d;
      stage_data_q <= stage_data_d;
    end
  end

  assign bus.rf_we    = stage_v_q;
  assign bus.rf_waddr = stage_addr_q;
  assign bus.rf_wdata = stage_data_q;

  // The staged write reaches the register file only at the end of the
  // rf_we cycle, so decode must take it from here during that cycle.
  assign fwd1_hit  = stage_v_q && (stage_addr_q == raddr1) && (raddr1 != '0);
  assign fwd2_hit  = stage_v_q && (stage_addr_q == raddr2) && (raddr2 != '0);
  assign fwd1_data = stage_data_q;
  assign fwd2_data = stage_data_q;

  // A request being granted this cycle still counts: its value is only
  // visible through the bypass from the next cycle on.
  assign busy1 = (raddr1 != '0) &&
                 ((req0.valid && (req0.addr == raddr1)) ||
                  (req1.valid && (req1.addr == raddr1)));
  assign busy2 = (raddr2 != '0) &&
                 ((req0.valid && (req0.addr == raddr2)) ||
                  (req1.valid && (req1.addr == raddr2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  logic [AW-1:0]    raddr1, raddr2;
  logic             fwd1_hit, fwd2_hit, busy1, busy2;
  logic [WIDTH-1:0] fwd1_data, fwd2_data;
  lg_e              dbg_last_grant;

  regfile_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .fwd1_hit       (fwd1_hit),
    .fwd2_hit       (fwd2_hit),
    .fwd1_data      (fwd1_data),
    .fwd2_data      (fwd2_data),
    .busy1          (busy1),
    .busy2          (busy2),
    .dbg_last_grant (dbg_last_grant)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  // m_last: 0 = port 0 served most recently, 1 = port 1.
  // exp_q holds the write expected on the register-file port this cycle.
  logic m_last = 1'b1;
  logic [AW+WIDTH-1:0] exp_q[$];

  function automatic logic [1:0] exp_gnt();
    logic [1:0] g;
    g = 2'b00;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) g = m_last ? 2'b01 : 2'b10;
      else g = {bus.req1_valid, bus.req0_valid};
    end
    return g;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    return (ra != 0) &&
           ((bus.req0_valid && bus.req0_addr == ra) ||
            (bus.req1_valid && bus.req1_addr == ra));
  endfunction

  function automatic logic exp_hit(input logic [AW-1:0] ra);
    logic [AW+WIDTH-1:0] e;
    if (exp_q.size() == 0 || ra == 0) return 1'b0;
    e = exp_q[0];
    return e[AW+WIDTH-1:WIDTH] == ra;
  endfunction

  // Advance the model across one rising edge using the inputs presented.
  task automatic model_clock();
    logic [1:0] g;
    g = exp_gnt();
    exp_q.delete();
    if (rst) begin
      m_last = 1'b1;
    end else if (g[0]) begin
      m_last = 1'b0;
      if (bus.req0_addr != 0) exp_q.push_back({bus.req0_addr, bus.req0_data});
    end else if (g[1]) begin
      m_last = 1'b1;
      if (bus.req1_addr != 0) exp_q.push_back({bus.req1_addr, bus.req1_data});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    raddr1 = 5'd3; raddr2 = 5'd0;
    @(negedge clk);
    n_total++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      $display("FAIL reset_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    n_total++;
    if (bus.rf_we !== 1'b0 || fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
      $display("FAIL reset_outputs: we=%b fwd1=%b fwd2=%b want 0 0 0", bus.rf_we, fwd1_hit, fwd2_hit);
    end else n_pass++;
    n_total++;
    if (dbg_last_grant !== LG1) begin
      $display("FAIL reset_last_grant: got %0d want 1", dbg_last_grant);
    end else n_pass++;
    tick();
  endtask

  task automatic test_single_req0();
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
    @(negedge clk);
    n_total++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      $display("FAIL single_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end else n_pass++;
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    n_total++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
      $display("FAIL single_write: we=%b addr=%0d data=%h want 1 5 deadbeef",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end else n_pass++;
    tick();
  endtask

  task automatic test_contention();
    logic [AW-1:0] want_addr;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i);
      else drive(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      if (i < 4) begin
        n_total++;
        if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
          $display("FAIL contention_grant[%0d]: got %b%b", i, bus.req0_ready, bus.req1_ready);
        end else n_pass++;
      end
      if (i > 0) begin
        want_addr = ((i - 1) % 2 == 0) ? 5'd1 : 5'd2;
        n_total++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== want_addr) begin
          $display("FAIL contention_waddr[%0d]: we=%b addr=%0d want 1 %0d", i, bus.rf_we, bus.rf_waddr, want_addr);
        end else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reg0();
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
    raddr1 = 5'd0; raddr2 = 5'd0;
    @(negedge clk);
    n_total++;
    if (bus.req1_ready !== 1'b1) begin
      $display("FAIL reg0_ready: got %b want 1", bus.req1_ready);
    end else n_pass++;
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    n_total++;
    if (bus.rf_we !== 1'b0 || fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
      $display("FAIL reg0_drop: we=%b fwd1=%b fwd2=%b want 0 0 0", bus.rf_we, fwd1_hit, fwd2_hit);
    end else n_pass++;
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 32'hCAFE, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    raddr1 = 5'd7; raddr2 = 5'd8;
    @(negedge clk);
    n_total++;
    if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hCAFE || fwd2_hit !== 1'b0) begin
      $display("FAIL bypass: fwd1=%b data=%h fwd2=%b want 1 cafe 0", fwd1_hit, fwd1_data, fwd2_hit);
    end else n_pass++;
    tick();
  endtask

  task automatic test_busy();
    // Make port 0 the most recent winner so it loses the next contention.
    drive(1'b1, 5'd3, 32'h33, 1'b0, '0, '0);
    raddr1 = 5'd0; raddr2 = 5'd9;
    tick();
    drive(1'b1, 5'd9, 32'h9999, 1'b1, 5'd4, 32'h44);
    @(negedge clk);
    n_total++;
    if (bus.req0_ready !== 1'b0 || busy2 !== 1'b1) begin
      $display("FAIL busy_losing: ready0=%b busy2=%b want 0 1", bus.req0_ready, busy2);
    end else n_pass++;
    tick();
    drive(1'b1, 5'd9, 32'h9999, 1'b1, 5'd6, 32'h66);
    @(negedge clk);
    n_total++;
    if (bus.req0_ready !== 1'b1 || busy2 !== 1'b1 || fwd2_hit !== 1'b0) begin
      $display("FAIL busy_granted: ready0=%b busy2=%b fwd2=%b want 1 1 0", bus.req0_ready, busy2, fwd2_hit);
    end else n_pass++;
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    n_total++;
    if (busy2 !== 1'b0 || fwd2_hit !== 1'b1 || fwd2_data !== 32'h9999) begin
      $display("FAIL busy_fwd: busy2=%b fwd2=%b data=%h want 0 1 9999", busy2, fwd2_hit, fwd2_data);
    end else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (fwd2_hit !== 1'b0) begin
      $display("FAIL busy_fwd_end: fwd2=%b want 0", fwd2_hit);
    end else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd11, 32'hB0B, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13);
    @(negedge clk);
    n_total++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      $display("FAIL rstmid_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.rf_we !== 1'b0) begin
      $display("FAIL rstmid_we: got %b want 0", bus.rf_we);
    end else n_pass++;
    n_total++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      $display("FAIL rstmid_first_grant: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] g;
    logic hold0 = 1'b0, hold1 = 1'b0;
    logic [AW+WIDTH-1:0] e;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!hold0) begin
        bus.req0_valid = $urandom_range(0, 1);
        bus.req0_addr  = AW'($urandom_range(0, 7));
        bus.req0_data  = $urandom;
      end
      if (!hold1) begin
        bus.req1_valid = $urandom_range(0, 1);
        bus.req1_addr  = AW'($urandom_range(0, 7));
        bus.req1_data  = $urandom;
      end
      raddr1 = AW'($urandom_range(0, 7));
      raddr2 = AW'($urandom_range(0, 7));
      @(negedge clk);
      g = exp_gnt();
      n_total++;
      if ({bus.req1_ready, bus.req0_ready} !== g) begin
        $display("FAIL rand_grant[%0d]: got %b%b want %b", c, bus.req1_ready, bus.req0_ready, g);
      end else n_pass++;
      n_total++;
      if (bus.rf_we !== (exp_q.size() != 0)) begin
        $display("FAIL rand_we[%0d]: got %b want %b", c, bus.rf_we, exp_q.size() != 0);
      end else n_pass++;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        n_total++;
        if ({bus.rf_waddr, bus.rf_wdata} !== e) begin
          $display("FAIL rand_write[%0d]: got %0d/%h want %0d/%h", c, bus.rf_waddr, bus.rf_wdata,
                   e[AW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end else n_pass++;
      end
      n_total++;
      if (fwd1_hit !== exp_hit(raddr1) || fwd2_hit !== exp_hit(raddr2)) begin
        $display("FAIL rand_fwd[%0d]: got %b%b want %b%b", c, fwd1_hit, fwd2_hit, exp_hit(raddr1), exp_hit(raddr2));
      end else n_pass++;
      if (exp_hit(raddr1)) begin
        e = exp_q[0];
        n_total++;
        if (fwd1_data !== e[WIDTH-1:0]) begin
          $display("FAIL rand_fwd1_data[%0d]: got %h want %h", c, fwd1_data, e[WIDTH-1:0]);
        end else n_pass++;
      end
      n_total++;
      if (busy1 !== exp_busy(raddr1) || busy2 !== exp_busy(raddr2)) begin
        $display("FAIL rand_busy[%0d]: got %b%b want %b%b", c, busy1, busy2, exp_busy(raddr1), exp_busy(raddr2));
      end else n_pass++;
      n_total++;
      if (dbg_last_grant !== lg_e'(m_last)) begin
        $display("FAIL rand_state[%0d]: got %0d want %0d", c, dbg_last_grant, m_last);
      end else n_pass++;
      hold0 = bus.req0_valid && !g[0];
      hold1 = bus.req1_valid && !g[1];
      tick();
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    raddr1 = '0; raddr2 = '0;
    test_reset();
    test_single_req0();
    test_contention();
    test_reg0();
    test_bypass();
    test_busy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
